// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle main control unit.
//   - Opcode values of the supported instruction subset
//   - ALUOp encodings handed to the ALU control block
//   - FSM state encoding (3 bits)
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ST    = 6'b010000;
  localparam logic [5:0] OP_LD    = 6'b010001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // add / and-imm / ld / st
  localparam logic [1:0] ALUOP_OR    = 2'b01;  // or-imm
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // funct field decides

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting on mem_ready.
//   clk, rst    : clock, asynchronous active-high reset
//   i_clear     : zero the count (takes priority over i_count)
//   i_count     : one more wait cycle elapsed
//   o_expired   : this wait cycle brings the count to TIMEOUT (never when TIMEOUT = 0)
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TMO_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam logic [TMO_W-1:0] L_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_count) r_cnt <= r_cnt + TMO_W'(1);
  end

  // Flags the wait cycle whose increment lands on TIMEOUT, so the trap is
  // taken on the same edge the count reaches the limit. Independent of
  // i_clear to keep the path from the FSM next-state logic loop-free.
  assign o_expired = (TIMEOUT != 0) && i_count && (r_cnt == L_LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes, handshakes with the unified memory, traps on timeout.
//   clk, rst            : clock, asynchronous active-high reset
//   run                 : permits a new fetch
//   opcode              : IR[31:26], valid from DECODE on
//   mem_ready           : memory completes the current request
//   mem_req, i_or_d     : memory request strobe, address select (0 PC / 1 ALUOut)
//   ir_write, pc_write  : IR load, PC <= PC+4
//   ALUOp .. MemToReg   : datapath control
//   illegal_op          : one-cycle pulse on an undefined opcode
//   bus_error           : sticky memory timeout flag
//   retired             : completed-instruction count
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned TMO_W    = 4,
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          ALUOp,
  output logic                RegDst,
  output logic                ALUSrc,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemToReg,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [OPCODE_W-1:0] L_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] L_ANDI  = OPCODE_W'(OP_ANDI);
  localparam logic [OPCODE_W-1:0] L_ORI   = OPCODE_W'(OP_ORI);
  localparam logic [OPCODE_W-1:0] L_ST    = OPCODE_W'(OP_ST);
  localparam logic [OPCODE_W-1:0] L_LD    = OPCODE_W'(OP_LD);

  state_t                r_state;
  logic [OPCODE_W-1:0]   r_op;
  logic [RETIRE_W-1:0]   r_retired;
  logic                  r_bus_error;

  state_t                w_state_fsm;
  state_t                w_state_nxt;
  logic                  w_retire;
  logic                  w_legal;
  logic                  w_tmo_clear;
  logic                  w_tmo_count;
  logic                  w_expired;

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      L_RTYPE, L_ANDI, L_ORI, L_ST, L_LD: w_legal = 1'b1;
      default:                            w_legal = 1'b0;
    endcase
  end

  // Strobes and FSM successor; rst forces every strobe low combinationally
  // so a write in flight is dropped the moment reset rises.
  always_comb begin
    mem_req     = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    ALUOp       = ALUOP_ADD;
    RegDst      = 1'b0;
    ALUSrc      = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    illegal_op  = 1'b0;
    w_retire    = 1'b0;
    w_state_fsm = r_state;
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          if (run) begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) begin
              ir_write    = 1'b1;
              pc_write    = 1'b1;
              w_state_fsm = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          if (w_legal) begin
            w_state_fsm = ST_EXEC;
          end else begin
            illegal_op  = 1'b1;
            w_state_fsm = ST_FETCH;
          end
        end
        ST_EXEC: begin
          if (r_op == L_RTYPE)    ALUOp = ALUOP_RTYPE;
          else if (r_op == L_ORI) ALUOp = ALUOP_OR;
          else                    ALUOp = ALUOP_ADD;
          ALUSrc      = (r_op != L_RTYPE);
          w_state_fsm = ((r_op == L_LD) || (r_op == L_ST)) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          i_or_d   = 1'b1;
          ALUSrc   = 1'b1;
          MemRead  = (r_op == L_LD);
          MemWrite = (r_op == L_ST);
          if (mem_ready) begin
            if (r_op == L_ST) begin
              w_retire    = 1'b1;
              w_state_fsm = ST_FETCH;
            end else begin
              w_state_fsm = ST_WB;
            end
          end
        end
        ST_WB: begin
          RegWrite    = 1'b1;
          RegDst      = (r_op == L_RTYPE);
          MemToReg    = (r_op == L_LD);
          w_retire    = 1'b1;
          w_state_fsm = ST_FETCH;
        end
        ST_HALT: ;
        default: w_state_fsm = ST_FETCH;
      endcase
    end
  end

  assign w_tmo_count = mem_req & ~mem_ready;
  assign w_tmo_clear = (mem_req & mem_ready) |
                       ((w_state_fsm != r_state) &&
                        ((w_state_fsm == ST_FETCH) || (w_state_fsm == ST_MEM)));

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_tmo_clear),
    .i_count   (w_tmo_count),
    .o_expired (w_expired)
  );

  assign w_state_nxt = w_expired ? ST_HALT : w_state_fsm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_op        <= '0;
      r_retired   <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_DECODE) r_op <= opcode;
      if (w_retire)             r_retired <= r_retired + RETIRE_W'(1);
      if (w_expired)            r_bus_error <= 1'b1;
    end
  end

  assign bus_error = r_bus_error;
  assign retired   = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each stimulus cycle pushes the
// hand-computed strobe vector and retired count into a scoreboard queue;
// a monitor on the falling edge pops and compares.
// Vector bit order: mem_req i_or_d ir_write pc_write | ALUOp[1:0] |
//                   RegDst ALUSrc RegWrite MemRead | MemWrite MemToReg illegal_op bus_error
module tb_multicycle_control;

  localparam logic [13:0] V_IDLE    = 14'b0000_00_0000_0000;
  localparam logic [13:0] V_F_WAIT  = 14'b1000_00_0001_0000;
  localparam logic [13:0] V_F_RDY   = 14'b1011_00_0001_0000;
  localparam logic [13:0] V_DEC     = 14'b0000_00_0000_0000;
  localparam logic [13:0] V_DEC_ILL = 14'b0000_00_0000_0010;
  localparam logic [13:0] V_EX_R    = 14'b0000_10_0000_0000;
  localparam logic [13:0] V_EX_ORI  = 14'b0000_01_0100_0000;
  localparam logic [13:0] V_EX_IMM  = 14'b0000_00_0100_0000;
  localparam logic [13:0] V_M_LD    = 14'b1100_00_0101_0000;
  localparam logic [13:0] V_M_ST    = 14'b1100_00_0100_1000;
  localparam logic [13:0] V_WB_LD   = 14'b0000_00_0010_0100;
  localparam logic [13:0] V_WB_R    = 14'b0000_00_1010_0000;
  localparam logic [13:0] V_WB_I    = 14'b0000_00_0010_0000;
  localparam logic [13:0] V_HALT    = 14'b0000_00_0000_0001;

  localparam logic [5:0] O_R   = 6'b000000;
  localparam logic [5:0] O_AND = 6'b001100;
  localparam logic [5:0] O_OR  = 6'b001101;
  localparam logic [5:0] O_ST  = 6'b010000;
  localparam logic [5:0] O_LD  = 6'b010001;
  localparam logic [5:0] O_BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, i_or_d, ir_write, pc_write;
  logic [1:0]  ALUOp;
  logic        RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg;
  logic        illegal_op, bus_error;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W (6),
    .TIMEOUT  (15),
    .TMO_W    (4),
    .RETIRE_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .ALUOp      (ALUOp),
    .RegDst     (RegDst),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .illegal_op (illegal_op),
    .bus_error  (bus_error),
    .retired    (retired)
  );

  typedef struct {
    logic [13:0] outs;
    logic [31:0] ret;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [13:0] w_outs;
  int          n_vec = 0;
  int          n_bad = 0;

  assign w_outs = {mem_req, i_or_d, ir_write, pc_write, ALUOp,
                   RegDst, ALUSrc, RegWrite, MemRead,
                   MemWrite, MemToReg, illegal_op, bus_error};

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      if (w_outs !== e.outs || retired !== e.ret) begin
        n_bad++;
        $display("FAIL %s: got outs=%b retired=%0d, expected outs=%b retired=%0d",
                 e.nm, w_outs, retired, e.outs, e.ret);
      end
    end
  end

  task automatic cyc(input logic r, input logic ru, input logic rdy,
                     input logic [5:0] op, input logic [13:0] ev,
                     input logic [31:0] ret, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst       = r;
    run       = ru;
    mem_ready = rdy;
    opcode    = op;
    x.outs = ev;
    x.ret  = ret;
    x.nm   = nm;
    sb.push_back(x);
  endtask

  initial begin
    // reset with run high: strobes must stay low
    cyc(1, 1, 1, O_R, V_IDLE, 0, "reset");

    // 1: zero-wait ld
    cyc(0, 1, 1, O_R,  V_F_RDY,  0, "ld_fetch");
    cyc(0, 1, 0, O_LD, V_DEC,    0, "ld_decode");
    cyc(0, 1, 0, O_R,  V_EX_IMM, 0, "ld_exec");
    cyc(0, 1, 1, O_R,  V_M_LD,   0, "ld_mem");
    cyc(0, 1, 0, O_R,  V_WB_LD,  0, "ld_wb");

    // 2: R-type then ori, back to back
    cyc(0, 1, 1, O_R,  V_F_RDY,  1, "r_fetch");
    cyc(0, 1, 0, O_R,  V_DEC,    1, "r_decode");
    cyc(0, 1, 0, O_R,  V_EX_R,   1, "r_exec");
    cyc(0, 1, 0, O_R,  V_WB_R,   1, "r_wb");
    cyc(0, 1, 1, O_R,  V_F_RDY,  2, "ori_fetch");
    cyc(0, 1, 0, O_OR, V_DEC,    2, "ori_decode");
    cyc(0, 1, 0, O_R,  V_EX_ORI, 2, "ori_exec");
    cyc(0, 1, 0, O_R,  V_WB_I,   2, "ori_wb");

    // 3: st with 3 wait cycles; stray mem_ready in DECODE/EXEC is ignored
    cyc(0, 1, 1, O_R,  V_F_RDY,  3, "st_fetch");
    cyc(0, 1, 1, O_ST, V_DEC,    3, "st_decode_stray_rdy");
    cyc(0, 1, 1, O_R,  V_EX_IMM, 3, "st_exec_stray_rdy");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, O_R, V_M_ST, 3, "st_mem_wait");
    cyc(0, 1, 1, O_R,  V_M_ST,   3, "st_mem_ready");

    // 4: illegal opcode
    cyc(0, 1, 1, O_R,   V_F_RDY,   4, "ill_fetch");
    cyc(0, 1, 0, O_BAD, V_DEC_ILL, 4, "ill_decode");

    // 5: fetch never answered -> trap after 15 wait cycles
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, O_R, V_F_WAIT, 4, "tmo_wait");
    for (int i = 0; i < 3; i++)  cyc(0, 1, 1, O_R, V_HALT, 4, "halt");
    cyc(1, 1, 1, O_R, V_IDLE, 0, "halt_reset");

    // 6: restart, then reset in the middle of a st MEM phase
    cyc(0, 1, 1, O_R,  V_F_RDY,  0, "st2_fetch");
    cyc(0, 1, 0, O_ST, V_DEC,    0, "st2_decode");
    cyc(0, 1, 0, O_R,  V_EX_IMM, 0, "st2_exec");
    cyc(0, 1, 0, O_R,  V_M_ST,   0, "st2_mem");
    cyc(1, 1, 0, O_R,  V_IDLE,   0, "st2_reset_mid_mem");
    cyc(0, 0, 1, O_R,  V_IDLE,   0, "run_low_idle");
    cyc(0, 0, 1, O_R,  V_IDLE,   0, "run_low_idle");

    // andi with run dropped after the fetch: instruction completes, no refetch
    cyc(0, 1, 1, O_R,   V_F_RDY,  0, "andi_fetch");
    cyc(0, 0, 0, O_AND, V_DEC,    0, "andi_decode");
    cyc(0, 0, 0, O_R,   V_EX_IMM, 0, "andi_exec");
    cyc(0, 0, 0, O_R,   V_WB_I,   0, "andi_wb");
    cyc(0, 0, 1, O_R,   V_IDLE,   1, "andi_after");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
